memory_access_unit: RTL and testbench
=====================================

# memory_access_unit

Synchronous word-addressed memory with a request/done handshake and programmable wait states. Sits directly downstream of the memory data register: the MDR drives write data into it and takes read data from it. The address comes from the memory address register, and the control sequencer issues requests. It models a slow memory so the sequencer must stall on `MEM_busy` instead of assuming single-cycle access.

## Interface
- `DATA_W`, 16, word width
- `ADDR_W`, 16, address width
- `DEPTH`, 256, number of words implemented; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W
- `WAIT_STATES`, 2, extra cycles per access, 0–15

- `MEM_clock` input 1: single clock; all state changes on its rising edge
- `MEM_reset_n` input 1: reset, asynchronous, active-low
- `MEM_req` input 1: access request, sampled only when `MEM_busy`=0
- `MEM_we` input 1: 1 = write, 0 = read; sampled with `MEM_req`
- `MEM_addr` input ADDR_W: word address, from MAR
- `MEM_data_to_memory` input DATA_W: write data, from MDR
- `MEM_data_from_memory` output DATA_W: read data, to MDR
- `MEM_busy` output 1: access in progress; requests ignored
- `MEM_done` output 1: one-cycle completion pulse
- `MEM_error` output 1: out-of-range address; valid only while `MEM_done`=1

## Operation
- Storage is an array of DEPTH words of DATA_W bits.
- Request capture:
  - Requests are accepted only when `MEM_busy`=0.
  - On an edge where `MEM_req`=1 and `MEM_busy`=0, the unit latches `MEM_we`, `MEM_addr` and `MEM_data_to_memory`.
  - Later changes on these inputs have no effect on the access in flight.
- FSM states:
  - IDLE → WAIT on request if WAIT_STATES>0, otherwise IDLE → ACCESS.
  - WAIT: a down-counter loaded with WAIT_STATES−1 decrements each cycle. WAIT → ACCESS when the counter is 0.
  - ACCESS → IDLE unconditionally.
- Actions on the ACCESS edge:
  - In-range write (latched addr < DEPTH): write the array.
  - In-range read: load `MEM_data_from_memory` with the array word.
  - Out of range: no array update. A read loads 0. `MEM_error`=1.
  - Always: `MEM_done`=1.
- `MEM_data_from_memory`:
  - Holds its value until the next read completes.
  - Writes do not change it.
- `MEM_req` while busy is ignored. It is not queued.

## Timing
- Reset values: `MEM_data_from_memory`=0, `MEM_done`=0, `MEM_error`=0, FSM=IDLE, counter=0. `MEM_busy`=0 without the configuration macro, 1 with it.
- Request accepted at edge k:
  - `MEM_busy`=1 from edge k until edge k+WAIT_STATES+1.
  - `MEM_done` and `MEM_error` valid in the cycle after edge k+WAIT_STATES+1.
  - Total latency: WAIT_STATES+1 cycles.
- `MEM_busy` and `MEM_done` are never both 1.
- `MEM_busy` falls at the same edge where `MEM_done` rises.
- Back-to-back: a request present during the `MEM_done` cycle is accepted, giving one access every WAIT_STATES+1 cycles.
- Read-after-write to the same address returns the new data.
- Reset asserted mid-access:
  - The access is aborted immediately and asynchronously.
  - A pending write is not performed.
  - No `MEM_done` pulse is issued.
- Address wrap: there is no aliasing. Any address ≥ DEPTH is an error.

## Configuration
- `MEM_CLEAR_ON_RESET_EN` defined:
  - After `MEM_reset_n` deasserts, the FSM enters a CLEAR state and writes 0 to addresses 0..DEPTH−1, one per cycle.
  - `MEM_busy`=1 throughout. `MEM_done` is not pulsed.
  - CLEAR → IDLE after the write to DEPTH−1; `MEM_busy` drops at that edge.
  - A reset during CLEAR restarts the clear at address 0.
- Not defined:
  - There is no CLEAR state; the FSM starts in IDLE.
  - Array contents are unaffected by reset and are unknown until written.

## Test plan
- WAIT_STATES=2: write 0xBEEF to addr 0x0010, then read 0x0010.
  - Each access has `MEM_busy` high for 3 cycles, then a 1-cycle `MEM_done`.
  - Read returns 0xBEEF with `MEM_error`=0.
- Back-to-back: hold `MEM_req`=1 with a read of 0x0010 through the `MEM_done` cycle.
  - The second access starts immediately.
  - `MEM_done` pulses every 3 cycles; the data is 0xBEEF both times.
- Out of range: read addr 0x0100 with DEPTH=256.
  - `MEM_done`=1, `MEM_error`=1, data=0x0000.
  - A write to 0x0100 leaves addresses 0x00–0xFF unchanged.
- Request while busy: pulse `MEM_req` (write 0x1234 to 0x0005) one cycle after a request is accepted.
  - The pulse is ignored; a later read of 0x0005 does not return 0x1234.
- Reset mid-write: assert `MEM_reset_n`=0 during WAIT of a write of 0xAAAA to 0x0020.
  - Outputs go to their reset values with no `MEM_done` pulse.
  - A later read of 0x0020 does not return 0xAAAA: it returns 0 with the macro, and the prior value without it.
- `MEM_CLEAR_ON_RESET_EN`, DEPTH=256:
  - `MEM_busy` stays high for exactly 256 cycles after reset release.
  - A read of 0x00FF then returns 0x0000.

Source files
------------

// File: rtl/memory_access_unit.sv
// Word-addressed memory with req/done handshake and programmable wait states; optional zero-fill after reset (MEM_CLEAR_ON_RESET_EN).
// Latency: WAIT_STATES+1 cycles from accepted request to the registered MEM_done/MEM_error/read-data cycle.
// Backpressure: MEM_busy=1 while an access (or clear) is in flight; requests seen while busy are dropped, not queued.
module memory_access_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              MEM_clock,
    input  logic              MEM_reset_n,
    input  logic              MEM_req,
    input  logic              MEM_we,
    input  logic [ADDR_W-1:0] MEM_addr,
    input  logic [DATA_W-1:0] MEM_data_to_memory,
    output logic [DATA_W-1:0] MEM_data_from_memory,
    output logic              MEM_busy,
    output logic              MEM_done,
    output logic              MEM_error
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          wait_cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdat_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                in_range;
    logic                mem_wr;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   mem_wdat;
    logic [DATA_W-1:0]   mem_rdat;

`ifdef MEM_CLEAR_ON_RESET_EN
    logic [IDX_W-1:0]    clear_idx_q;
`endif

    assign accept   = (state_q == ST_IDLE) && MEM_req;
    // Zero-extend so an address equal to 2^ADDR_W-1 compares correctly when DEPTH = 2^ADDR_W.
    assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
    assign mem_rdat = mem[mem_idx];

    // State register
    always_ff @(posedge MEM_clock or negedge MEM_reset_n) begin
        if (!MEM_reset_n) begin
`ifdef MEM_CLEAR_ON_RESET_EN
            state_q <= ST_CLEAR;
`else
            state_q <= ST_IDLE;
`endif
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (MEM_req) begin
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
`ifdef MEM_CLEAR_ON_RESET_EN
                if (clear_idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / array-port decode
    always_comb begin
        MEM_busy = (state_q != ST_IDLE);
        mem_wr   = 1'b0;
        mem_idx  = addr_q[IDX_W-1:0];
        mem_wdat = wdat_q;
        case (state_q)
            ST_ACCESS: begin
                mem_wr = we_q && in_range;
            end
`ifdef MEM_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                mem_wr   = 1'b1;
                mem_idx  = clear_idx_q;
                mem_wdat = '0;
            end
`endif
            default: begin
                mem_wr = 1'b0;
            end
        endcase
    end

    // Request fields are frozen at acceptance so MAR/MDR may move on during the access.
    always_ff @(posedge MEM_clock or negedge MEM_reset_n) begin
        if (!MEM_reset_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
        end else if (accept) begin
            we_q   <= MEM_we;
            addr_q <= MEM_addr;
            wdat_q <= MEM_data_to_memory;
        end
    end

    always_ff @(posedge MEM_clock or negedge MEM_reset_n) begin
        if (!MEM_reset_n) begin
            wait_cnt_q <= 4'd0;
        end else if (accept) begin
            wait_cnt_q <= WAIT_LOAD;
        end else if ((state_q == ST_WAIT) && (wait_cnt_q != 4'd0)) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge MEM_clock or negedge MEM_reset_n) begin
        if (!MEM_reset_n) begin
            MEM_done             <= 1'b0;
            MEM_error            <= 1'b0;
            MEM_data_from_memory <= '0;
        end else begin
            MEM_done  <= (state_q == ST_ACCESS);
            MEM_error <= (state_q == ST_ACCESS) && !in_range;
            if ((state_q == ST_ACCESS) && !we_q) begin
                MEM_data_from_memory <= in_range ? mem_rdat : '0;
            end
        end
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    always_ff @(posedge MEM_clock or negedge MEM_reset_n) begin
        if (!MEM_reset_n) begin
            clear_idx_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clear_idx_q <= clear_idx_q + IDX_W'(1);
        end
    end
`endif

    // Storage has no reset; aborted accesses never reach ST_ACCESS, so no write leaks out.
    always_ff @(posedge MEM_clock) begin
        if (mem_wr) begin
            mem[mem_idx] <= mem_wdat;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: vector table with a done-driven scoreboard plus reset/busy corner sequences.
module tb_memory_access_unit;

    localparam int WS = 2;
`ifdef MEM_CLEAR_ON_RESET_EN
    localparam logic CLR = 1'b1;
`else
    localparam logic CLR = 1'b0;
`endif

    logic        MEM_clock = 1'b0;
    logic        MEM_reset_n;
    logic        MEM_req;
    logic        MEM_we;
    logic [15:0] MEM_addr;
    logic [15:0] MEM_data_to_memory;
    logic [15:0] MEM_data_from_memory;
    logic        MEM_busy;
    logic        MEM_done;
    logic        MEM_error;

    memory_access_unit #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(WS)
    ) dut (
        .MEM_clock            (MEM_clock),
        .MEM_reset_n          (MEM_reset_n),
        .MEM_req              (MEM_req),
        .MEM_we               (MEM_we),
        .MEM_addr             (MEM_addr),
        .MEM_data_to_memory   (MEM_data_to_memory),
        .MEM_data_from_memory (MEM_data_from_memory),
        .MEM_busy             (MEM_busy),
        .MEM_done             (MEM_done),
        .MEM_error            (MEM_error)
    );

    always #5 MEM_clock = ~MEM_clock;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdat;
        logic [15:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [13];
    logic [16:0] sb_q [$];
    logic [16:0] sb_e;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge MEM_clock) begin
        if (MEM_done === 1'b1) begin
            check("busy_with_done", {31'd0, MEM_busy}, 32'd0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
            end else begin
                sb_e = sb_q.pop_front();
                check("rd_data", {16'd0, MEM_data_from_memory}, {16'd0, sb_e[16:1]});
                check("error", {31'd0, MEM_error}, {31'd0, sb_e[0]});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that raises MEM_done.
    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_d, input logic exp_e, input bit poke);
        int guard;
        int lat;
        int busy_cyc;
        guard = 0;
        while (MEM_busy && guard < 2000) begin
            @(posedge MEM_clock); #1;
            guard++;
        end
        check("idle_before_req", {31'd0, MEM_busy}, 32'd0);
        MEM_req            = 1'b1;
        MEM_we             = we;
        MEM_addr           = a;
        MEM_data_to_memory = d;
        sb_q.push_back({exp_d, exp_e});
        @(posedge MEM_clock); #1;
        MEM_req            = 1'b0;
        MEM_we             = ~we;
        MEM_addr           = 16'($urandom);
        MEM_data_to_memory = 16'($urandom);
        lat      = 0;
        busy_cyc = 0;
        while (!MEM_done && lat < 50) begin
            if (MEM_busy) busy_cyc++;
            if (poke) begin
                MEM_req            = (lat == 0);
                MEM_we             = 1'b1;
                MEM_addr           = 16'h0005;
                MEM_data_to_memory = 16'h1234;
            end
            @(posedge MEM_clock); #1;
            lat++;
        end
        MEM_req = 1'b0;
        check("latency", lat, WS + 1);
        check("busy_cycles", busy_cyc, WS + 1);
    endtask

    task automatic wait_clear();
        int cnt;
        cnt = 0;
        while (MEM_busy && cnt < 1000) begin
            @(posedge MEM_clock); #1;
            cnt++;
        end
        check("clear_busy_cycles", cnt, 256);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b1, 16'h0000, 16'h2222, 16'hBEEF, 1'b0};
        vecs[4]  = '{1'b1, 16'h00FF, 16'h1111, 16'hBEEF, 1'b0};
        vecs[5]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{1'b1, 16'h0100, 16'h5555, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h2222, 1'b0};
        vecs[8]  = '{1'b1, 16'h0005, 16'h0077, 16'h2222, 1'b0};
        vecs[9]  = '{1'b0, 16'h00FF, 16'h0000, 16'h1111, 1'b0};
        vecs[10] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 16'h0005, 16'h0000, 16'h0077, 1'b0};
        vecs[12] = '{1'b1, 16'h0020, 16'h3333, 16'h0077, 1'b0};

        MEM_req            = 1'b0;
        MEM_we             = 1'b0;
        MEM_addr           = 16'h0000;
        MEM_data_to_memory = 16'h0000;
        MEM_reset_n        = 1'b1;
        #2 MEM_reset_n     = 1'b0;
        repeat (2) @(posedge MEM_clock);
        #1;
        check("rst_data", {16'd0, MEM_data_from_memory}, 32'd0);
        check("rst_done", {31'd0, MEM_done}, 32'd0);
        check("rst_error", {31'd0, MEM_error}, 32'd0);
        check("rst_busy", {31'd0, MEM_busy}, {31'd0, CLR});
        MEM_reset_n = 1'b1;
`ifdef MEM_CLEAR_ON_RESET_EN
        wait_clear();
        access(1'b0, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 1'b0);
`else
        @(posedge MEM_clock); #1;
`endif

        // Consecutive calls issue during the previous done cycle, i.e. back-to-back.
        for (int i = 0; i < 13; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdat, vecs[i].exp_dat, vecs[i].exp_err, 1'b0);
        end

        // Write request pulsed while busy must be dropped.
        access(1'b0, 16'h0000, 16'h0000, 16'h2222, 1'b0, 1'b1);
        access(1'b0, 16'h0005, 16'h0000, 16'h0077, 1'b0, 1'b0);

        // Reset during the wait phase of a write aborts it with no done pulse.
        @(posedge MEM_clock); #1;
        MEM_req            = 1'b1;
        MEM_we             = 1'b1;
        MEM_addr           = 16'h0020;
        MEM_data_to_memory = 16'hAAAA;
        @(posedge MEM_clock); #1;
        MEM_req = 1'b0;
        @(posedge MEM_clock); #2;
        MEM_reset_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, MEM_busy}, {31'd0, CLR});
        check("midrst_done", {31'd0, MEM_done}, 32'd0);
        check("midrst_error", {31'd0, MEM_error}, 32'd0);
        check("midrst_data", {16'd0, MEM_data_from_memory}, 32'd0);
        repeat (3) @(posedge MEM_clock);
        #1;
        MEM_reset_n = 1'b1;
`ifdef MEM_CLEAR_ON_RESET_EN
        wait_clear();
`else
        @(posedge MEM_clock); #1;
`endif
        access(1'b0, 16'h0020, 16'h0000, (CLR ? 16'h0000 : 16'h3333), 1'b0, 1'b0);

        repeat (3) @(posedge MEM_clock);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
